hpi_target_responder: RTL and testbench
=======================================

// Module: hpi_target_responder
// PURPOSE
//  Synthesizable responder for the OTG HPI bus: the target end of the PIO-driven host port (addr/cs/r/w/data/reset).
//  Emulates the CY7C67200 HPI register view: DATA, MAILBOX, ADDRESS and STATUS.
//  Backed by a local word RAM and a bidirectional mailbox.
//  Used as a loopback target for NIOS HPI driver bring-up and as the bench model for the USB host path.
// PARAMETERS
//  MEM_AW    8        word-address width of backing RAM (2**MEM_AW x 16-bit words)
//  RST_ADDR  16'h0000 HPI ADDRESS register value after reset
// PORTS
//  Clk             in   1   system clock; all logic on rising edge
//  Reset           in   1   synchronous, active-high; clears all state
//  hpi_address     in   2   register select: 0=DATA 1=MAILBOX 2=ADDRESS 3=STATUS
//  hpi_cs_n        in   1   chip select, active-low
//  hpi_r_n         in   1   read strobe, active-low
//  hpi_w_n         in   1   write strobe, active-low
//  hpi_reset_n     in   1   HPI reset, active-low; synchronous, same effect as Reset
//  hpi_data_in     in   16  write data from initiator
//  hpi_data_out    out  16  read data to initiator
//  dev_mbx_in      out  16  last host-written mailbox word
//  dev_mbx_valid   out  1   inbound mailbox full
//  dev_mbx_ack     in   1   device consumes inbound mailbox
//  dev_mbx_wr      in   1   device posts outbound mailbox word
//  dev_mbx_wdata   in   16  outbound mailbox word
// BEHAVIOUR
//  Reset / hpi_reset_n=0:
//   hpi_data_out=0, addr_reg=RST_ADDR, both mailboxes=0, all status flags=0, strobe history=1 (inactive).
//   RAM contents are not cleared.
//  Strobe sampling: cs_n, r_n, w_n registered once for edge detection.
//  Write:
//   - Commits on the cycle w_n is low with cs_n low and previous w_n high; one commit per strobe.
//   - DATA: RAM[addr_reg[MEM_AW:1]] <= data_in, then addr_reg += 2 (16-bit wrap).
//   - MAILBOX: mbx_in <= data_in, dev_mbx_valid <= 1. If it was already 1, set STATUS.OVR.
//   - ADDRESS: addr_reg <= data_in.
//   - STATUS: ignored.
//  Read:
//   - While cs_n=0 and r_n=0, hpi_data_out <= selected value every cycle (1-cycle latency).
//   - Otherwise hpi_data_out holds its last value.
//   - DATA: RAM[addr_reg[MEM_AW:1]]. MAILBOX: mbx_out. ADDRESS: addr_reg.
//   - STATUS: {12'h0, PERR, OVR, IN_FULL, OUT_FULL}.
//   - Side effects fire once, on the cycle r_n rises after an active read, using the hpi_address latched at read start:
//     - DATA: addr_reg += 2.
//     - MAILBOX: OUT_FULL <= 0.
//     - STATUS: OVR <= 0 and PERR <= 0.
//  Protocol error: r_n and w_n both low with cs_n low.
//   - No commit, no side effect; PERR <= 1.
//   - The strobe must return high before the next access is accepted.
//  cs_n rising mid-read aborts the read: no side effect.
//  Address wrap: bits above MEM_AW of addr_reg ignored for RAM index; bit 0 ignored (byte address, word access).
//  Device side:
//   - dev_mbx_ack clears dev_mbx_valid.
//   - dev_mbx_wr loads mbx_out and sets OUT_FULL.
//   - Same-cycle collisions:
//     - dev_mbx_wr with host MAILBOX read completion: write wins, OUT_FULL stays 1.
//     - dev_mbx_ack with host MAILBOX write: write wins, dev_mbx_valid stays 1, no OVR.
//  FSM (per access): IDLE -> RD_ACTIVE (cs_n&r_n low) -> IDLE on r_n rise (side effect) or cs_n rise (abort).
//   IDLE -> WR_HOLD on write commit; WR_HOLD -> IDLE when w_n high. Any state -> ERR on r_n&w_n low; ERR -> IDLE when both high.
// STRUCTURE
//  Package hpi_pkg: localparams HPI_DATA=2'd0, HPI_MAILBOX=2'd1, HPI_ADDR=2'd2, HPI_STATUS=2'd3.
//   Status bit indices ST_OUT_FULL=0, ST_IN_FULL=1, ST_OVR=2, ST_PERR=3. Enum hpi_state_t {IDLE, RD_ACTIVE, WR_HOLD, ERR}.
//  Sub-module hpi_word_ram: single-port 2**MEM_AW x16, synchronous write, synchronous read; index from addr_reg.
// TESTING
//  1 Write ADDRESS=16'h0010, write DATA 16'hBEEF, 16'hCAFE, write ADDRESS=16'h0010, read DATA twice
//    -> returns BEEF then CAFE; ADDRESS reads 16'h0014.
//  2 Host write MAILBOX 16'h1234 -> dev_mbx_in=1234, dev_mbx_valid=1, STATUS=0x0002.
//    Second write before ack -> STATUS=0x0006. STATUS read clears OVR -> next STATUS=0x0002.
//  3 dev_mbx_wr 16'h00A5 -> STATUS bit0=1; host read MAILBOX -> 00A5, STATUS=0x0000 after r_n rise.
//    Repeat with dev_mbx_wr in completion cycle -> bit0 stays 1.
//  4 ADDRESS=16'hFFFE, write DATA 16'h0001 -> addr wraps to 16'h0000;
//    with MEM_AW=8, ADDRESS=16'h0200 aliases word 0.
//  5 r_n and w_n low together on DATA -> no RAM change, addr_reg unchanged, STATUS=0x0008.
//    Abort read via cs_n rise -> addr_reg unchanged.
//  6 Mid-burst hpi_reset_n=0 for 1 cycle -> hpi_data_out=0, ADDRESS reads RST_ADDR, STATUS=0, RAM retained.

Source files
------------

// File: rtl/hpi_pkg.sv
// hpi_pkg: HPI register selects, STATUS bit positions and access-state encoding shared by the HPI target
package hpi_pkg;
  localparam logic [1:0] HPI_DATA    = 2'd0;
  localparam logic [1:0] HPI_MAILBOX = 2'd1;
  localparam logic [1:0] HPI_ADDR    = 2'd2;
  localparam logic [1:0] HPI_STATUS  = 2'd3;
  localparam int ST_OUT_FULL = 0;
  localparam int ST_IN_FULL  = 1;
  localparam int ST_OVR      = 2;
  localparam int ST_PERR     = 3;
  typedef enum logic [1:0] {IDLE, RD_ACTIVE, WR_HOLD, ERR} hpi_state_t;
endpackage

// File: rtl/hpi_word_ram.sv
// hpi_word_ram: 2**AW x 16 single-port RAM; clk, we/wdata sync write at idx, re loads q from idx (q holds otherwise)
module hpi_word_ram #(
  parameter int AW = 8
) (
  input  logic          clk,
  input  logic          we,
  input  logic          re,
  input  logic [AW-1:0] idx,
  input  logic [15:0]   wdata,
  output logic [15:0]   q
);
  logic [15:0] mem [2**AW];
  always_ff @(posedge clk) begin
    if (we) mem[idx] <= wdata;
    if (re) q <= mem[idx];
  end
endmodule

// File: rtl/hpi_target_responder.sv
// hpi_target_responder: CY7C67200-style HPI target (DATA/MAILBOX/ADDRESS/STATUS) over host strobes Clk/Reset/hpi_*, with device mailbox port dev_mbx_*
module hpi_target_responder
  import hpi_pkg::*;
#(
  parameter int          MEM_AW   = 8,
  parameter logic [15:0] RST_ADDR = 16'h0000
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic [1:0]  hpi_address,
  input  logic        hpi_cs_n,
  input  logic        hpi_r_n,
  input  logic        hpi_w_n,
  input  logic        hpi_reset_n,
  input  logic [15:0] hpi_data_in,
  output logic [15:0] hpi_data_out,
  output logic [15:0] dev_mbx_in,
  output logic        dev_mbx_valid,
  input  logic        dev_mbx_ack,
  input  logic        dev_mbx_wr,
  input  logic [15:0] dev_mbx_wdata
);
  hpi_state_t state, state_n;
  logic rst, cs_q, r_q, w_q, from_ram, perr_now, rd_on, rd_done, wr_commit;
  logic [1:0] rd_sel;
  logic [3:0] st;
  logic [15:0] addr_reg, mbx_out, out_q, rd_val, ram_q;
  assign rst = Reset || !hpi_reset_n;
  assign dev_mbx_valid = st[ST_IN_FULL];
  assign hpi_data_out = from_ram ? ram_q : out_q;
  always_comb begin
    perr_now = !hpi_cs_n && !hpi_r_n && !hpi_w_n;
    rd_on = !hpi_cs_n && !hpi_r_n && hpi_w_n && (state == IDLE || state == RD_ACTIVE);
    wr_commit = state == IDLE && !hpi_cs_n && !hpi_w_n && hpi_r_n && w_q;
    rd_done = state == RD_ACTIVE && !hpi_cs_n && !cs_q && hpi_r_n && !r_q;
    rd_val = hpi_address == HPI_MAILBOX ? mbx_out :
             hpi_address == HPI_ADDR ? addr_reg : {12'h0, st};
    state_n = perr_now ? ERR :
              state == IDLE ? (wr_commit ? WR_HOLD : rd_on ? RD_ACTIVE : IDLE) :
              state == RD_ACTIVE ? ((hpi_cs_n || hpi_r_n) ? IDLE : RD_ACTIVE) :
              state == WR_HOLD ? (hpi_w_n ? IDLE : WR_HOLD) :
              ((hpi_r_n && hpi_w_n) ? IDLE : ERR);
  end
  hpi_word_ram #(.AW(MEM_AW)) u_ram (
    .clk  (Clk),
    .we   (wr_commit && hpi_address == HPI_DATA),
    .re   (rd_on && hpi_address == HPI_DATA),
    .idx  (addr_reg[MEM_AW:1]),
    .wdata(hpi_data_in),
    .q    (ram_q)
  );
  always_ff @(posedge Clk) begin
    if (rst) begin
      state <= IDLE;
      cs_q <= 1'b1;
      r_q <= 1'b1;
      w_q <= 1'b1;
      addr_reg <= RST_ADDR;
      rd_sel <= HPI_DATA;
      from_ram <= 1'b0;
      out_q <= 16'h0;
      dev_mbx_in <= 16'h0;
      mbx_out <= 16'h0;
      st <= 4'h0;
    end else begin
      state <= state_n;
      cs_q <= hpi_cs_n;
      r_q <= hpi_r_n;
      w_q <= hpi_w_n;
      if (state == IDLE && rd_on) rd_sel <= hpi_address;
      if (rd_on) begin
        from_ram <= hpi_address == HPI_DATA;
        out_q <= rd_val;
      end
      if ((wr_commit && hpi_address == HPI_DATA) || (rd_done && rd_sel == HPI_DATA)) addr_reg <= addr_reg + 16'd2;
      else if (wr_commit && hpi_address == HPI_ADDR) addr_reg <= hpi_data_in;
      if (rd_done && rd_sel == HPI_STATUS) begin
        st[ST_OVR] <= 1'b0;
        st[ST_PERR] <= 1'b0;
      end
      if (perr_now) st[ST_PERR] <= 1'b1;
      if (wr_commit && hpi_address == HPI_MAILBOX) begin
        dev_mbx_in <= hpi_data_in;
        st[ST_IN_FULL] <= 1'b1;
        if (st[ST_IN_FULL] && !dev_mbx_ack) st[ST_OVR] <= 1'b1;
      end else if (dev_mbx_ack) st[ST_IN_FULL] <= 1'b0;
      if (dev_mbx_wr) begin
        mbx_out <= dev_mbx_wdata;
        st[ST_OUT_FULL] <= 1'b1;
      end else if (rd_done && rd_sel == HPI_MAILBOX) st[ST_OUT_FULL] <= 1'b0;
    end
  end
endmodule

// File: tb/tb_hpi_target_responder.sv
// tb_hpi_target_responder: directed HPI transactions checked against a transaction-level register/RAM model
module tb_hpi_target_responder;
  import hpi_pkg::*;
  logic Clk, Reset, hpi_cs_n, hpi_r_n, hpi_w_n, hpi_reset_n, dev_mbx_valid, dev_mbx_ack, dev_mbx_wr;
  logic [1:0] hpi_address;
  logic [15:0] hpi_data_in, hpi_data_out, dev_mbx_in, dev_mbx_wdata, d;
  logic [15:0] mem [256];
  logic [15:0] m_addr, m_mbx_in, m_mbx_out, m_dout;
  logic m_valid, m_ofull, m_ovr, m_perr, chk_en;
  int tests = 0, fails = 0;

  hpi_target_responder #(.MEM_AW(8), .RST_ADDR(16'h0000)) dut (
    .Clk(Clk), .Reset(Reset), .hpi_address(hpi_address), .hpi_cs_n(hpi_cs_n),
    .hpi_r_n(hpi_r_n), .hpi_w_n(hpi_w_n), .hpi_reset_n(hpi_reset_n),
    .hpi_data_in(hpi_data_in), .hpi_data_out(hpi_data_out), .dev_mbx_in(dev_mbx_in),
    .dev_mbx_valid(dev_mbx_valid), .dev_mbx_ack(dev_mbx_ack), .dev_mbx_wr(dev_mbx_wr),
    .dev_mbx_wdata(dev_mbx_wdata)
  );

  initial begin
    Clk = 1'b0;
    forever #5 Clk = ~Clk;
  end

  task automatic chk(input string n, input logic [15:0] a, input logic [15:0] e);
    tests++;
    if (a !== e) begin
      fails++;
      $display("FAIL %s: got %h expected %h", n, a, e);
    end
  endtask

  always @(negedge Clk) if (chk_en) begin
    chk("dout", hpi_data_out, m_dout);
    chk("mbx_in", dev_mbx_in, m_mbx_in);
    chk("mbx_valid", {15'h0, dev_mbx_valid}, {15'h0, m_valid});
  end

  task automatic cyc();
    @(posedge Clk);
    #1;
  endtask

  task automatic model_reset();
    m_addr = 16'h0000;
    m_mbx_in = 16'h0;
    m_mbx_out = 16'h0;
    m_dout = 16'h0;
    {m_valid, m_ofull, m_ovr, m_perr} = 4'h0;
  endtask

  function automatic logic [15:0] mval(input logic [1:0] a);
    logic [7:0] wi;
    wi = m_addr[8:1];
    return a == HPI_DATA ? mem[wi] : a == HPI_MAILBOX ? m_mbx_out :
           a == HPI_ADDR ? m_addr : {12'h0, m_perr, m_ovr, m_valid, m_ofull};
  endfunction

  task automatic hw(input logic [1:0] a, input logic [15:0] v, input logic ack);
    hpi_address = a;
    hpi_data_in = v;
    hpi_cs_n = 1'b0;
    hpi_w_n = 1'b0;
    dev_mbx_ack = ack;
    cyc();
    if (a == HPI_DATA) begin
      mem[m_addr[8:1]] = v;
      m_addr = m_addr + 16'd2;
    end else if (a == HPI_ADDR) m_addr = v;
    if (a == HPI_MAILBOX) begin
      if (m_valid && !ack) m_ovr = 1'b1;
      m_mbx_in = v;
      m_valid = 1'b1;
    end else if (ack) m_valid = 1'b0;
    dev_mbx_ack = 1'b0;
    hpi_w_n = 1'b1;
    cyc();
    hpi_cs_n = 1'b1;
    cyc();
  endtask

  task automatic hr(input logic [1:0] a, input logic dwr, input logic [15:0] dwd, output logic [15:0] v);
    hpi_address = a;
    hpi_cs_n = 1'b0;
    hpi_r_n = 1'b0;
    cyc();
    m_dout = mval(a);
    cyc();
    m_dout = mval(a);
    hpi_r_n = 1'b1;
    dev_mbx_wr = dwr;
    dev_mbx_wdata = dwd;
    cyc();
    if (a == HPI_DATA) m_addr = m_addr + 16'd2;
    if (a == HPI_MAILBOX) m_ofull = 1'b0;
    if (a == HPI_STATUS) {m_ovr, m_perr} = 2'b00;
    if (dwr) begin
      m_mbx_out = dwd;
      m_ofull = 1'b1;
    end
    dev_mbx_wr = 1'b0;
    hpi_cs_n = 1'b1;
    cyc();
    v = hpi_data_out;
  endtask

  task automatic dev_wr(input logic [15:0] v);
    dev_mbx_wr = 1'b1;
    dev_mbx_wdata = v;
    cyc();
    m_mbx_out = v;
    m_ofull = 1'b1;
    dev_mbx_wr = 1'b0;
  endtask

  task automatic dev_ack();
    dev_mbx_ack = 1'b1;
    cyc();
    m_valid = 1'b0;
    dev_mbx_ack = 1'b0;
  endtask

  initial begin
    chk_en = 1'b0;
    {hpi_cs_n, hpi_r_n, hpi_w_n, hpi_reset_n} = 4'hF;
    {dev_mbx_ack, dev_mbx_wr} = 2'b00;
    hpi_address = HPI_DATA;
    hpi_data_in = 16'h0;
    dev_mbx_wdata = 16'h0;
    Reset = 1'b1;
    cyc();
    cyc();
    Reset = 1'b0;
    model_reset();
    chk_en = 1'b1;
    cyc();
    chk("rst_dout", hpi_data_out, 16'h0000);
    hr(HPI_STATUS, 1'b0, 16'h0, d); chk("rst_status", d, 16'h0000);
    hr(HPI_ADDR, 1'b0, 16'h0, d);   chk("rst_addr", d, 16'h0000);
    // 1: RAM write/readback with auto-increment
    hw(HPI_ADDR, 16'h0010, 1'b0);
    hw(HPI_DATA, 16'hBEEF, 1'b0);
    hw(HPI_DATA, 16'hCAFE, 1'b0);
    hw(HPI_ADDR, 16'h0010, 1'b0);
    hr(HPI_DATA, 1'b0, 16'h0, d); chk("t1_rd0", d, 16'hBEEF);
    hr(HPI_DATA, 1'b0, 16'h0, d); chk("t1_rd1", d, 16'hCAFE);
    hr(HPI_ADDR, 1'b0, 16'h0, d); chk("t1_addr", d, 16'h0014);
    // 2: inbound mailbox, overrun, ack collision
    hw(HPI_MAILBOX, 16'h1234, 1'b0);
    chk("t2_mbx_in", dev_mbx_in, 16'h1234);
    hr(HPI_STATUS, 1'b0, 16'h0, d); chk("t2_st0", d, 16'h0002);
    hw(HPI_MAILBOX, 16'h5678, 1'b0);
    hr(HPI_STATUS, 1'b0, 16'h0, d); chk("t2_st_ovr", d, 16'h0006);
    hr(HPI_STATUS, 1'b0, 16'h0, d); chk("t2_st_clr", d, 16'h0002);
    dev_ack();
    chk("t2_acked", {15'h0, dev_mbx_valid}, 16'h0000);
    hw(HPI_MAILBOX, 16'h1111, 1'b0);
    hw(HPI_MAILBOX, 16'h2222, 1'b1);
    hr(HPI_STATUS, 1'b0, 16'h0, d); chk("t2_ack_coll", d, 16'h0002);
    dev_ack();
    // 3: outbound mailbox and device-write collision on read completion
    dev_wr(16'h00A5);
    hr(HPI_STATUS, 1'b0, 16'h0, d); chk("t3_st_out", d, 16'h0001);
    hr(HPI_MAILBOX, 1'b0, 16'h0, d); chk("t3_mbx", d, 16'h00A5);
    hr(HPI_STATUS, 1'b0, 16'h0, d); chk("t3_st_clr", d, 16'h0000);
    dev_wr(16'h005A);
    hr(HPI_MAILBOX, 1'b1, 16'h00C3, d); chk("t3_mbx2", d, 16'h005A);
    hr(HPI_STATUS, 1'b0, 16'h0, d); chk("t3_coll", d, 16'h0001);
    hr(HPI_MAILBOX, 1'b0, 16'h0, d); chk("t3_mbx3", d, 16'h00C3);
    // 4: address wrap and aliasing
    hw(HPI_ADDR, 16'hFFFE, 1'b0);
    hw(HPI_DATA, 16'h0001, 1'b0);
    hr(HPI_ADDR, 1'b0, 16'h0, d); chk("t4_wrap", d, 16'h0000);
    hw(HPI_DATA, 16'h7777, 1'b0);
    hw(HPI_ADDR, 16'h0200, 1'b0);
    hr(HPI_DATA, 1'b0, 16'h0, d); chk("t4_alias", d, 16'h7777);
    hw(HPI_ADDR, 16'hFFFE, 1'b0);
    hr(HPI_DATA, 1'b0, 16'h0, d); chk("t4_top", d, 16'h0001);
    // 5: protocol error and aborted read
    hw(HPI_ADDR, 16'h0020, 1'b0);
    hw(HPI_DATA, 16'hAAAA, 1'b0);
    hw(HPI_ADDR, 16'h0020, 1'b0);
    hpi_address = HPI_DATA;
    hpi_data_in = 16'h5555;
    hpi_cs_n = 1'b0;
    hpi_r_n = 1'b0;
    hpi_w_n = 1'b0;
    cyc();
    m_perr = 1'b1;
    hpi_r_n = 1'b1;
    hpi_w_n = 1'b1;
    cyc();
    hpi_cs_n = 1'b1;
    cyc();
    hr(HPI_ADDR, 1'b0, 16'h0, d); chk("t5_addr", d, 16'h0020);
    hr(HPI_DATA, 1'b0, 16'h0, d); chk("t5_ram", d, 16'hAAAA);
    hr(HPI_STATUS, 1'b0, 16'h0, d); chk("t5_perr", d, 16'h0008);
    hw(HPI_ADDR, 16'h0020, 1'b0);
    hpi_address = HPI_DATA;
    hpi_cs_n = 1'b0;
    hpi_r_n = 1'b0;
    cyc();
    m_dout = mval(HPI_DATA);
    hpi_cs_n = 1'b1;
    cyc();
    hpi_r_n = 1'b1;
    cyc();
    hr(HPI_ADDR, 1'b0, 16'h0, d); chk("t5_abort", d, 16'h0020);
    // 6: HPI reset in the middle of a read burst
    hw(HPI_ADDR, 16'h0040, 1'b0);
    hw(HPI_DATA, 16'h0F0F, 1'b0);
    hw(HPI_DATA, 16'hF0F0, 1'b0);
    hw(HPI_MAILBOX, 16'h4242, 1'b0);
    dev_wr(16'h1357);
    hw(HPI_ADDR, 16'h0040, 1'b0);
    hpi_address = HPI_DATA;
    hpi_cs_n = 1'b0;
    hpi_r_n = 1'b0;
    cyc();
    m_dout = mval(HPI_DATA);
    chk("t6_burst", hpi_data_out, 16'h0F0F);
    hpi_reset_n = 1'b0;
    hpi_cs_n = 1'b1;
    hpi_r_n = 1'b1;
    cyc();
    model_reset();
    hpi_reset_n = 1'b1;
    cyc();
    chk("t6_dout", hpi_data_out, 16'h0000);
    chk("t6_valid", {15'h0, dev_mbx_valid}, 16'h0000);
    hr(HPI_ADDR, 1'b0, 16'h0, d);    chk("t6_addr", d, 16'h0000);
    hr(HPI_STATUS, 1'b0, 16'h0, d);  chk("t6_status", d, 16'h0000);
    hr(HPI_MAILBOX, 1'b0, 16'h0, d); chk("t6_mbx", d, 16'h0000);
    hw(HPI_ADDR, 16'h0040, 1'b0);
    hr(HPI_DATA, 1'b0, 16'h0, d); chk("t6_ram0", d, 16'h0F0F);
    hr(HPI_DATA, 1'b0, 16'h0, d); chk("t6_ram1", d, 16'hF0F0);
    cyc();
    chk_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
